// File: rtl/spi_slave_bank.sv
// SPI slave that shifts master words into a MOSI register bank and serves words from a processor-written MISO bank.
// Build macro SPI_SLAVE_BANK_BURST_EN enables header-B burst transfers with address auto-increment.
`timescale 1ns/1ps
module spi_slave_bank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter bit CPOL   = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              SPI_CLK,
    input  logic              SPI_CS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    input  logic              Data_WE,
    input  logic [31:0]       Data_Addr_write,
    input  logic [31:0]       Data_Addr_read,
    input  logic [DATA_W-1:0] Data_Write,
    output logic [DATA_W-1:0] Data_Read,
    output logic              Mosi_Wr_Pulse,
    output logic [ADDR_W-1:0] Mosi_Wr_Addr,
    output logic              Frame_Done
);

    localparam int            DEPTH     = 1 << ADDR_W;
    localparam logic [5:0]    HDR_BITS  = 6'd8;
    localparam logic [5:0]    WORD_BITS = 6'(DATA_W);

    typedef enum logic [1:0] {IDLE, HDR, DATA, HOLD} state_t;

    state_t              state, state_nxt;
    logic                sclk_p0, sclk_p1, sclk_p2;
    logic                cs_p0, cs_p1;
    logic                mosi_p0, mosi_p1;
    logic                vld_p0, vld_p1;
    logic                armed;
    logic                lead, trail, word_end;
    logic [5:0]          cnt;
    logic [DATA_W-1:0]   rx_sr, tx_sr;
    logic [ADDR_W-1:0]   addr;
    logic                wr_en, hdr_seen, miso_r;
    logic [DATA_W-1:0]   wr_data_p0;
    logic                burst;
    logic [DATA_W-1:0]   miso_ram [DEPTH];
    logic [DATA_W-1:0]   mosi_ram [DEPTH];

    // ---- stage p0/p1: synchronisers; p2 holds the previous SPI_CLK for edge detection
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sclk_p0 <= CPOL;
            sclk_p1 <= CPOL;
            sclk_p2 <= CPOL;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sclk_p0 <= SPI_CLK;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= SPI_CS;
            cs_p1   <= cs_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            // A frame is only accepted once a genuine CS-high has been seen since reset
            if (vld_p1 && cs_p1)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        mosi_p0 <= SPI_MOSI;
        mosi_p1 <= mosi_p0;
    end

    assign lead     = (sclk_p1 != sclk_p2) && (sclk_p1 != CPOL);
    assign trail    = (sclk_p1 != sclk_p2) && (sclk_p1 == CPOL);
    assign word_end = (state == DATA) && lead && (cnt == WORD_BITS - 6'd1);

    always_ff @(posedge Clk) begin
        if (!Reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (armed && !cs_p1) state_nxt = HDR;
            HDR: begin
                if (cs_p1)
                    state_nxt = IDLE;
                else if (trail && cnt == HDR_BITS)
                    state_nxt = DATA;
            end
            DATA: begin
                if (cs_p1)
                    state_nxt = IDLE;
                else if (word_end && !burst)
                    state_nxt = HOLD;
            end
            HOLD: if (cs_p1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef SPI_SLAVE_BANK_BURST_EN
    logic [ADDR_W-1:0] addr_inc;
    assign addr_inc = addr + ADDR_W'(1);
`else
    assign burst = 1'b0;
`endif

    // ---- shift datapath, driven by the detected SPI edges
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt           <= '0;
            rx_sr         <= '0;
            tx_sr         <= '0;
            addr          <= '0;
            wr_en         <= 1'b0;
            hdr_seen      <= 1'b0;
            miso_r        <= 1'b0;
            wr_data_p0    <= '0;
            Mosi_Wr_Pulse <= 1'b0;
            Mosi_Wr_Addr  <= '0;
            Frame_Done    <= 1'b0;
`ifdef SPI_SLAVE_BANK_BURST_EN
            burst         <= 1'b0;
`endif
        end else begin
            Mosi_Wr_Pulse <= 1'b0;
            Frame_Done    <= (state != IDLE) && cs_p1 && hdr_seen;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    rx_sr    <= '0;
                    tx_sr    <= '0;
                    addr     <= '0;
                    hdr_seen <= 1'b0;
                    miso_r   <= 1'b0;
                end
                HDR: if (!cs_p1) begin
                    if (lead && cnt < HDR_BITS) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], mosi_p1};
                        cnt   <= cnt + 6'd1;
                        if (cnt == HDR_BITS - 6'd1)
                            hdr_seen <= 1'b1;
                    end else if (trail && cnt == HDR_BITS) begin
                        wr_en  <= rx_sr[7];
`ifdef SPI_SLAVE_BANK_BURST_EN
                        burst  <= rx_sr[6];
`endif
                        addr   <= rx_sr[ADDR_W-1:0];
                        tx_sr  <= miso_ram[rx_sr[ADDR_W-1:0]];
                        miso_r <= miso_ram[rx_sr[ADDR_W-1:0]][DATA_W-1];
                        rx_sr  <= '0;
                        cnt    <= '0;
                    end
                end
                DATA: if (!cs_p1) begin
                    if (lead && cnt < WORD_BITS) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], mosi_p1};
                        cnt   <= cnt + 6'd1;
                        if (word_end) begin
                            if (wr_en) begin
                                Mosi_Wr_Pulse <= 1'b1;
                                Mosi_Wr_Addr  <= addr;
                                wr_data_p0    <= {rx_sr[DATA_W-2:0], mosi_p1};
                            end
                            if (!burst)
                                miso_r <= 1'b0;
                        end
                    end else if (trail) begin
`ifdef SPI_SLAVE_BANK_BURST_EN
                        if (cnt == WORD_BITS) begin
                            addr   <= addr_inc;
                            tx_sr  <= miso_ram[addr_inc];
                            miso_r <= miso_ram[addr_inc][DATA_W-1];
                            cnt    <= '0;
                        end else begin
                            tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                            miso_r <= tx_sr[DATA_W-2];
                        end
`else
                        tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
                        miso_r <= tx_sr[DATA_W-2];
`endif
                    end
                end
                HOLD: miso_r <= 1'b0;
                default: miso_r <= 1'b0;
            endcase
        end
    end

    assign SPI_MISO = miso_r;

    // ---- register banks; the MOSI commit lands one Clk after its pulse
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                miso_ram[i] <= '0;
        end else if (Data_WE) begin
            miso_ram[Data_Addr_write[ADDR_W+1:2]] <= Data_Write;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mosi_ram[i] <= '0;
        end else if (Mosi_Wr_Pulse) begin
            mosi_ram[Mosi_Wr_Addr] <= wr_data_p0;
        end
    end

    assign Data_Read = mosi_ram[Data_Addr_read[ADDR_W+1:2]];

    logic unused_bits;
    assign unused_bits = ^{Data_Addr_write[31:ADDR_W+2], Data_Addr_write[1:0],
                           Data_Addr_read[31:ADDR_W+2], Data_Addr_read[1:0],
                           rx_sr[DATA_W-1], tx_sr[DATA_W-1]};

endmodule

// File: tb/tb_spi_slave_bank.sv
// Directed bench for spi_slave_bank: a bank/queue model predicts commits, MISO words and frame pulses.
`timescale 1ns/1ps
module tb_spi_slave_bank;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam bit CPOL_B = 1'b0;
    localparam int HALF   = 6;

    logic          Clk = 1'b0;
    logic          Reset_n, SPI_CLK, SPI_CS, SPI_MOSI, SPI_MISO;
    logic          Data_WE;
    logic [31:0]   Data_Addr_write, Data_Addr_read;
    logic [DW-1:0] Data_Write, Data_Read;
    logic          Mosi_Wr_Pulse, Frame_Done;
    logic [AW-1:0] Mosi_Wr_Addr;

    always #5 Clk = ~Clk;

    spi_slave_bank #(.DATA_W(DW), .ADDR_W(AW), .CPOL(CPOL_B)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .SPI_CLK(SPI_CLK), .SPI_CS(SPI_CS),
        .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .Data_WE(Data_WE),
        .Data_Addr_write(Data_Addr_write), .Data_Addr_read(Data_Addr_read),
        .Data_Write(Data_Write), .Data_Read(Data_Read), .Mosi_Wr_Pulse(Mosi_Wr_Pulse),
        .Mosi_Wr_Addr(Mosi_Wr_Addr), .Frame_Done(Frame_Done)
    );

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

    int            n_cmp = 0, n_fail = 0;
    int            wr_cnt = 0, fd_cnt = 0;
    logic          mon_en = 1'b0, miso_zero = 1'b0;
    logic [DW-1:0] exp_mosi [1<<AW];
    logic [DW-1:0] exp_miso [1<<AW];
    wr_t           wq[$];
    logic [DW-1:0] mosi_words [4];
    logic [DW-1:0] miso_got [4];
    logic [DW-1:0] miso_exp [4];
    logic          hdr_miso;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Per-cycle compare against the bank model; commits become visible one Clk after their pulse
    task automatic monitor();
        wr_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en) begin
                check("data_read", Data_Read, exp_mosi[Data_Addr_read[AW+1:2]]);
                if (miso_zero)
                    check("miso_idle", DW'(SPI_MISO), '0);
                if (Frame_Done)
                    fd_cnt++;
                if (Mosi_Wr_Pulse) begin
                    wr_cnt++;
                    check("wr_pulse_expected", DW'(wq.size() != 0), DW'(1));
                    if (wq.size() != 0) begin
                        e = wq.pop_front();
                        check("wr_addr", DW'(Mosi_Wr_Addr), DW'(e.a));
                        exp_mosi[e.a] = e.d;
                    end
                end
            end
        end
    endtask

    task automatic cpu_write(input int idx, input logic [DW-1:0] d);
        @(negedge Clk);
        Data_WE         = 1'b1;
        Data_Addr_write = 32'(idx) << 2;
        Data_Write      = d;
        @(negedge Clk);
        Data_WE         = 1'b0;
        exp_miso[idx]   = d;
    endtask

    task automatic read_lit(input string name, input int idx, input logic [DW-1:0] exp);
        @(negedge Clk);
        Data_Addr_read = 32'(idx) << 2;
        #1;
        check(name, Data_Read, exp);
    endtask

    // Clocks header then ndata data bits with CS already low; MOSI changes on trailing edges
    task automatic spi_shift(input logic [7:0] hdr, input int ndata);
        hdr_miso = 1'b0;
        for (int k = 0; k < 4; k++) miso_got[k] = '0;
        for (int i = 0; i < 8 + ndata; i++) begin
            int j;
            j = i - 8;
            if (i < 8) SPI_MOSI = hdr[7-i];
            else       SPI_MOSI = mosi_words[j/DW][DW-1-(j%DW)];
            repeat (HALF) @(negedge Clk);
            SPI_CLK = ~CPOL_B;
            if (i < 8) hdr_miso = hdr_miso | SPI_MISO;
            else       miso_got[j/DW][DW-1-(j%DW)] = SPI_MISO;
            repeat (HALF) @(negedge Clk);
            SPI_CLK = CPOL_B;
        end
    endtask

    task automatic spi_frame(input string tag, input logic [7:0] hdr, input int ndata);
        logic          b;
        logic [AW-1:0] a0;
        logic [DW-1:0] ones;
        int            nfull, nwords, fd0, nb;
`ifdef SPI_SLAVE_BANK_BURST_EN
        b = hdr[6];
`else
        b = 1'b0;
`endif
        a0    = hdr[AW-1:0];
        ones  = '1;
        nfull = ndata / DW;
        if (!b && nfull > 1) nfull = 1;
        if (hdr[7])
            for (int k = 0; k < nfull; k++)
                wq.push_back({AW'(32'(a0) + k), mosi_words[k]});
        nwords = (ndata + DW - 1) / DW;
        for (int k = 0; k < 4; k++) begin
            miso_exp[k] = (k > 0 && !b) ? '0 : exp_miso[AW'(32'(a0) + k)];
            nb = ndata - k * DW;
            if (k >= nwords)  miso_exp[k] = '0;
            else if (nb < DW) miso_exp[k] = miso_exp[k] & ~(ones >> nb);
        end
        Data_Addr_read = 32'(a0) << 2;
        miso_zero = 1'b0;
        fd0 = fd_cnt;
        @(negedge Clk);
        SPI_CS = 1'b0;
        repeat (6) @(negedge Clk);
        spi_shift(hdr, ndata);
        repeat (HALF) @(negedge Clk);
        SPI_CS = 1'b1;
        repeat (8) @(negedge Clk);
        miso_zero = 1'b1;
        check({tag, "_hdr_miso"}, DW'(hdr_miso), '0);
        for (int k = 0; k < nwords; k++)
            check($sformatf("%s_miso_w%0d", tag, k), miso_got[k], miso_exp[k]);
        check({tag, "_frame_done"}, DW'(fd_cnt - fd0), DW'(1));
        check({tag, "_wr_missing"}, DW'(wq.size()), '0);
        wq.delete();
    endtask

    initial begin
        int w0, fd0;
        SPI_CLK = CPOL_B; SPI_CS = 1'b1; SPI_MOSI = 1'b0; Reset_n = 1'b0;
        Data_WE = 1'b0; Data_Addr_write = '0; Data_Addr_read = '0; Data_Write = '0;
        for (int i = 0; i < (1<<AW); i++) begin
            exp_mosi[i] = '0;
            exp_miso[i] = '0;
        end
        fork
            monitor();
        join_none

        repeat (4) @(negedge Clk);
        check("rst_miso", DW'(SPI_MISO), '0);
        check("rst_wr_pulse", DW'(Mosi_Wr_Pulse), '0);
        check("rst_wr_addr", DW'(Mosi_Wr_Addr), '0);
        check("rst_frame_done", DW'(Frame_Done), '0);
        check("rst_data_read", Data_Read, '0);
        Reset_n = 1'b1; mon_en = 1'b1; miso_zero = 1'b1;
        repeat (5) @(negedge Clk);

        // write frame to index 3
        mosi_words[0] = 32'hDEADBEEF;
        w0 = wr_cnt;
        spi_frame("r029", 8'h83, 32);
        check("r029_wr_count", DW'(wr_cnt - w0), DW'(1));
        check("r029_wr_addr_lit", DW'(Mosi_Wr_Addr), DW'(3));
        read_lit("r029_bank3_lit", 3, 32'hDEADBEEF);

        // read-only frame from index 5
        cpu_write(5, 32'h12345678);
        mosi_words[0] = 32'hFFFF0000;
        w0 = wr_cnt;
        spi_frame("r030", 8'h05, 32);
        check("r030_miso_lit", miso_got[0], 32'h12345678);
        check("r030_no_write", DW'(wr_cnt - w0), '0);

        // full write then an aborted partial write to index 2
        mosi_words[0] = 32'hA5A5A5A5;
        spi_frame("r032a", 8'h82, 32);
        mosi_words[0] = 32'h11111111;
        w0 = wr_cnt;
        spi_frame("r032b", 8'h82, 20);
        check("r032_no_write", DW'(wr_cnt - w0), '0);
        read_lit("r032_bank2_lit", 2, 32'hA5A5A5A5);

`ifdef SPI_SLAVE_BANK_BURST_EN
        cpu_write(15, 32'hF0F0F0F0);
        cpu_write(0, 32'h0BADF00D);
        cpu_write(1, 32'hCAFEBABE);
        mosi_words[0] = 32'h01010101;
        mosi_words[1] = 32'h02020202;
        mosi_words[2] = 32'h03030303;
        w0 = wr_cnt;
        spi_frame("r031", 8'hCF, 96);
        check("r031_wr_count", DW'(wr_cnt - w0), DW'(3));
        check("r031_miso0_lit", miso_got[0], 32'hF0F0F0F0);
        check("r031_miso1_lit", miso_got[1], 32'h0BADF00D);
        check("r031_miso2_lit", miso_got[2], 32'hCAFEBABE);
        read_lit("r031_bank15_lit", 15, 32'h01010101);
        read_lit("r031_bank0_lit", 0, 32'h02020202);
        read_lit("r031_bank1_lit", 1, 32'h03030303);
`else
        cpu_write(1, 32'h5A5A5A5A);
        mosi_words[0] = 32'h13579BDF;
        mosi_words[1] = 32'h2468ACE0;
        w0 = wr_cnt;
        spi_frame("r034", 8'hC1, 64);
        check("r034_wr_count", DW'(wr_cnt - w0), DW'(1));
        check("r034_miso0_lit", miso_got[0], 32'h5A5A5A5A);
        check("r034_miso1_lit", miso_got[1], '0);
        read_lit("r034_bank1_lit", 1, 32'h13579BDF);
        read_lit("r034_bank2_lit", 2, 32'hA5A5A5A5);
`endif

        // reset mid-word, CS held low afterwards
        cpu_write(2, 32'hFFFFFFFF);
        mosi_words[0] = 32'hFFFFFFFF;
        Data_Addr_read = 32'd8;
        miso_zero = 1'b0;
        fd0 = fd_cnt;
        w0 = wr_cnt;
        @(negedge Clk);
        SPI_CS = 1'b0;
        repeat (6) @(negedge Clk);
        spi_shift(8'h82, 10);
        Reset_n = 1'b0;
        miso_zero = 1'b1;
        for (int i = 0; i < (1<<AW); i++) begin
            exp_mosi[i] = '0;
            exp_miso[i] = '0;
        end
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        cpu_write(3, 32'hFFFFFFFF);
        Data_Addr_read = 32'd12;
        spi_shift(8'h83, 32);
        check("r033_miso_lit", miso_got[0], '0);
        repeat (HALF) @(negedge Clk);
        SPI_CS = 1'b1;
        repeat (8) @(negedge Clk);
        check("r033_no_frame_done", DW'(fd_cnt - fd0), '0);
        check("r033_no_write", DW'(wr_cnt - w0), '0);
        read_lit("r033_bank2_cleared", 2, '0);

        // frame accepted again after CS toggles
        mosi_words[0] = 32'h0;
        spi_frame("r033_after", 8'h03, 32);
        check("r033_after_miso_lit", miso_got[0], 32'hFFFFFFFF);

        for (int i = 0; i < (1<<AW); i++) begin
            @(negedge Clk);
            Data_Addr_read = 32'(i) << 2;
        end
        repeat (2) @(negedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
